// File: rtl/spi_chan_sel_pkg.sv
// Shared types and constants for the SPI channel selector.
// State encodings, default blanking level and blanking-length bounds.
package spi_chan_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic        IDLE_BIT      = 1'b1;
  localparam int unsigned BLANK_CYC_MIN = 1;
  localparam int unsigned BLANK_CYC_MAX = 255;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/mux_nto1.sv
// Purely combinational N-to-1 lane selector.
// Lane k occupies lanes_i[k*W +: W].
module mux_nto1 #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] lanes_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      lane_o
);

  assign lane_o = lanes_i[int'(sel_i) * W +: W];

endmodule

// File: rtl/spi_chan_sel_mux.sv
// Handshaked N-to-1 channel selector; switches only when the frame is idle, then blanks.
// Optional SPI_CHAN_SEL_OUT_REG_EN registers the out port (one extra cycle of latency).
module spi_chan_sel_mux
  import spi_chan_sel_pkg::*;
#(
  parameter int unsigned   N_CH      = 8,
  parameter int unsigned   W         = 1,
  parameter int unsigned   BLANK_CYC = 2,
  parameter logic [W-1:0]  IDLE_VAL  = {W{IDLE_BIT}},
  localparam int unsigned  SEL_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in,
  input  logic              busy,
  input  logic [SEL_W-1:0]  sel_data,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              switching,
  output logic              sel_err,
  output logic [W-1:0]      out
);

  if (BLANK_CYC < BLANK_CYC_MIN || BLANK_CYC > BLANK_CYC_MAX) begin : g_bad_blank
    $error("BLANK_CYC out of range");
  end

  state_e           state_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_err_q;
  logic             sel_oob;
  logic [W-1:0]     lane;
  logic [W-1:0]     out_comb;

  // Only reachable when N_CH is not a power of two.
  assign sel_oob = {1'b0, sel_data} >= (SEL_W + 1)'(N_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            if (sel_oob) begin
              sel_err_q <= 1'b1;
            end else if (sel_data != cur_sel_q) begin
              pending_q <= sel_data;
              if (busy) begin
                state_q <= ST_WAIT;
              end else begin
                state_q   <= ST_BLANK;
                cur_sel_q <= sel_data;
                cnt_q     <= CNT_W'(BLANK_CYC - 1);
              end
            end
          end
        end
        ST_WAIT: begin
          if (!busy) begin
            state_q   <= ST_BLANK;
            cur_sel_q <= pending_q;
            cnt_q     <= CNT_W'(BLANK_CYC - 1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_ready = (state_q == ST_IDLE);
  assign switching = (state_q != ST_IDLE);
  assign cur_sel   = cur_sel_q;
  assign sel_err   = sel_err_q;

  mux_nto1 #(
    .N_CH (N_CH),
    .W    (W),
    .SEL_W(SEL_W)
  ) u_mux (
    .lanes_i(in),
    .sel_i  (cur_sel_q),
    .lane_o (lane)
  );

  // Reset also blanks so the line idles before the first clock edge has been seen.
  assign out_comb = (rst || state_q == ST_BLANK) ? IDLE_VAL : lane;

`ifdef SPI_CHAN_SEL_OUT_REG_EN
  logic [W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= IDLE_VAL;
    end else begin
      out_q <= out_comb;
    end
  end

  assign out = out_q;
`else
  assign out = out_comb;
`endif

endmodule
